// File: rtl/seven_seg_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scheduler
// Description : Shares the seven-segment display peripheral between two write
//               requesters. A round-robin arbiter grants one write at a time
//               and walks it through IDLE -> WRITE -> ACK. The last written
//               word is kept as a shadow copy. The low/high page select
//               alternates every DWELL_CYCLES cycles unless the upper half of
//               the shadow is zero or paging is frozen by hold.
// Ports       : clock, reset          - clock, async active-high reset
//               req0_valid/data/ready - requester 0 handshake (ready = pulse)
//               req1_valid/data/ready - requester 1 handshake (ready = pulse)
//               hold                  - freezes the dwell counter and page
//               disp_write/disp_wdata - one-cycle write strobe and its word
//               disp_low_high         - page select (0 = [15:0], 1 = [31:16])
//               shadow_value          - last successfully written word
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scheduler #(
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int CNT_W        = 26
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  input  logic        hold,
  output logic        disp_write,
  output logic [31:0] disp_wdata,
  output logic        disp_low_high,
  output logic [31:0] shadow_value
);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_WRITE = 2'd1;
  localparam logic [1:0] c_ST_ACK   = 2'd2;

  localparam logic [CNT_W-1:0] c_TC = CNT_W'(DWELL_CYCLES - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic             r_last_grant;  // also identifies the requester in flight
  logic [31:0]      r_wdata;
  logic [31:0]      r_shadow;
  logic [CNT_W-1:0] r_cnt;
  logic             r_page;

  logic w_any_valid;
  logic w_pick1;

  assign w_any_valid = req0_valid | req1_valid;
  // Requester 1 wins when it is alone, or when both ask and 0 went last.
  assign w_pick1     = req1_valid & (~req0_valid | ~r_last_grant);

  // --------------------------------------------------------------------------
  // Arbiter state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Arbiter next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE:  if (w_any_valid) w_next_state = c_ST_WRITE;
      c_ST_WRITE: w_next_state = c_ST_ACK;
      c_ST_ACK:   w_next_state = c_ST_IDLE;
      default:    w_next_state = c_ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Arbiter outputs (decoded from state so reset clears them immediately)
  // --------------------------------------------------------------------------
  always_comb begin
    disp_write = 1'b0;
    disp_wdata = 32'h0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (r_state)
      c_ST_WRITE: begin
        disp_write = 1'b1;
        disp_wdata = r_wdata;
      end
      c_ST_ACK: begin
        req0_ready = ~r_last_grant;
        req1_ready = r_last_grant;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Grant bookkeeping, write latch and shadow copy. The shadow is loaded on
  // the edge entering ACK, i.e. the same edge that raises ready.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_wdata      <= 32'h0;
      r_shadow     <= 32'h0;
    end else begin
      if (r_state == c_ST_IDLE && w_any_valid) begin
        r_last_grant <= w_pick1;
        r_wdata      <= w_pick1 ? req1_data : req0_data;
      end
      if (r_state == c_ST_WRITE) begin
        r_shadow <= r_wdata;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Paging. A zero upper half parks the pager at page 0 / count 0, which
  // takes priority over hold, so paging restarts cleanly once it is nonzero.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_page <= 1'b0;
    end else if (r_shadow[31:16] == 16'h0) begin
      r_cnt  <= '0;
      r_page <= 1'b0;
    end else if (!hold) begin
      if (r_cnt == c_TC) begin
        r_cnt  <= '0;
        r_page <= ~r_page;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign disp_low_high = r_page;
  assign shadow_value  = r_shadow;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_seg_scheduler
// Description : Self-checking bench for seven_seg_scheduler (DWELL_CYCLES=4).
//               A transaction-timed reference model predicts every output
//               each cycle: a grant taken in cycle t strobes the display in
//               t+1, acknowledges and updates the shadow in t+2, and frees
//               the arbiter in t+3. The page is derived from the number of
//               unheld, unsuppressed cycles divided by the dwell period.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scheduler;

  localparam int DWELL = 4;
  localparam int CW    = 3;

  logic        clock;
  logic        reset;
  logic        req0_valid;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        hold;
  logic        disp_write;
  logic [31:0] disp_wdata;
  logic        disp_low_high;
  logic [31:0] shadow_value;

  seven_seg_scheduler #(
    .DWELL_CYCLES(DWELL),
    .CNT_W       (CW)
  ) u_dut (
    .clock        (clock),
    .reset        (reset),
    .req0_valid   (req0_valid),
    .req0_data    (req0_data),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_data    (req1_data),
    .req1_ready   (req1_ready),
    .hold         (hold),
    .disp_write   (disp_write),
    .disp_wdata   (disp_wdata),
    .disp_low_high(disp_low_high),
    .shadow_value (shadow_value)
  );

  always #5 clock = ~clock;

  int n_tests;
  int n_fail;

  // Reference model state
  int          m_cyc;
  bit          m_act;
  int          m_start;
  int          m_id;
  logic [31:0] m_data;
  int          m_last;
  logic [31:0] m_shadow;
  int          m_active;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h expected %h", tag, m_cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cyc    = 0;
    m_act    = 0;
    m_start  = 0;
    m_id     = 0;
    m_data   = 32'h0;
    m_last   = 1;
    m_shadow = 32'h0;
    m_active = 0;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 2) == 0) w[31:16] = 16'h0;
    return w;
  endfunction

  // mode 0: inputs untouched; 1: requester drops valid on its ready;
  // mode 2: fully random requesters and hold.
  task automatic drive_req(input bit rdy, input bit granted, input int mode,
                           inout logic v, inout logic [31:0] d);
    if (rdy) begin
      if (mode == 2 && $urandom_range(0, 1) == 1) d = rand_word();
      else if (mode >= 1) v = 1'b0;
    end else if (mode == 2) begin
      if (!v) begin
        if ($urandom_range(0, 9) < 4) begin
          v = 1'b1;
          d = rand_word();
        end
      end else if (granted && $urandom_range(0, 1) == 1) begin
        d = rand_word();
      end
    end
  endtask

  // Called at a falling edge: check this cycle, drive inputs for the coming
  // rising edge, advance the model across it, then wait a cycle.
  task automatic step(input int mode);
    bit e_wr;
    bit e_r0;
    bit e_r1;
    e_wr = m_act && (m_cyc == m_start + 1);
    e_r0 = m_act && (m_cyc == m_start + 2) && (m_id == 0);
    e_r1 = m_act && (m_cyc == m_start + 2) && (m_id == 1);
    check("disp_write",    32'(disp_write),    32'(e_wr));
    check("disp_wdata",    disp_wdata,         e_wr ? m_data : 32'h0);
    check("req0_ready",    32'(req0_ready),    32'(e_r0));
    check("req1_ready",    32'(req1_ready),    32'(e_r1));
    check("shadow_value",  shadow_value,       m_shadow);
    check("disp_low_high", 32'(disp_low_high), 32'((m_active / DWELL) % 2));

    drive_req(e_r0, m_act && m_id == 0, mode, req0_valid, req0_data);
    drive_req(e_r1, m_act && m_id == 1, mode, req1_valid, req1_data);
    if (mode == 2 && $urandom_range(0, 7) == 0) hold = ~hold;

    if (m_shadow[31:16] == 16'h0) m_active = 0;
    else if (!hold)               m_active++;
    if (m_act && m_cyc == m_start + 1) m_shadow = m_data;
    if (m_act && m_cyc == m_start + 2) begin
      m_act = 0;
    end else if (!m_act && (req0_valid || req1_valid)) begin
      if (req0_valid && req1_valid) m_id = 1 - m_last;
      else                          m_id = req1_valid ? 1 : 0;
      m_act   = 1;
      m_start = m_cyc;
      m_data  = (m_id == 1) ? req1_data : req0_data;
      m_last  = m_id;
    end
    m_cyc++;
    @(negedge clock);
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    clock      = 1'b0;
    reset      = 1'b1;
    req0_valid = 1'b0;
    req0_data  = 32'h0;
    req1_valid = 1'b0;
    req1_data  = 32'h0;
    hold       = 1'b0;
    model_reset();

    repeat (2) @(negedge clock);
    check("rst disp_write",    32'(disp_write),    32'h0);
    check("rst disp_wdata",    disp_wdata,         32'h0);
    check("rst req0_ready",    32'(req0_ready),    32'h0);
    check("rst req1_ready",    32'(req1_ready),    32'h0);
    check("rst shadow_value",  shadow_value,       32'h0);
    check("rst disp_low_high", 32'(disp_low_high), 32'h0);
    reset = 1'b0;
    model_reset();

    // Contention from reset: grants 0,1,0,1 with acks at cycles 2,5,8,11.
    req0_valid = 1'b1; req0_data = 32'hAAAA_0001;
    req1_valid = 1'b1; req1_data = 32'hBBBB_0002;
    repeat (12) step(0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (3) step(1);

    // Paging with a nonzero upper half, a hold window, then suppression.
    req0_valid = 1'b1; req0_data = 32'hDEAD_BEEF;
    repeat (20) step(1);
    hold = 1'b1;
    repeat (10) step(1);
    hold = 1'b0;
    repeat (6) step(1);
    req1_valid = 1'b1; req1_data = 32'h0000_BEEF;
    repeat (8) step(1);

    // Reset asserted during the WRITE cycle.
    req0_valid = 1'b1; req0_data = 32'h0000_1234;
    step(1);
    check("pre-reset disp_write", 32'(disp_write), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("async disp_write",   32'(disp_write),   32'h0);
    check("async disp_wdata",   disp_wdata,        32'h0);
    check("async shadow_value", shadow_value,      32'h0);
    check("async req0_ready",   32'(req0_ready),   32'h0);
    @(posedge clock);
    @(negedge clock);
    check("in-reset req0_ready", 32'(req0_ready), 32'h0);
    reset = 1'b0;
    model_reset();
    repeat (6) step(1);

    // Randomised traffic with random hold.
    repeat (3000) step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
